// File: rtl/sipo_rx_pkg.sv
// Shared constants for the serial-in parallel-out receiver.
package sipo_rx_pkg;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;
endpackage

// File: rtl/sipo_shift_reg.sv
// Width-bit MSB-first shift register with bit enable and synchronous load-zero.
module sipo_shift_reg #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             d_i,
  output logic [Width-1:0] q_o
);
  // A clear coinciding with a strobe keeps that bit as the first of a fresh frame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      q_o <= '0;
    else if (clr_i) q_o <= {{(Width-1){1'b0}}, d_i & en_i};
    else if (en_i)  q_o <= {q_o[Width-2:0], d_i};
  end
endmodule

// File: rtl/sipo_rx.sv
// Serial-in parallel-out deserializer: frames Width bits MSB first into a
// holding register presented with a valid/ack handshake and sticky overrun.
module sipo_rx #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             d_i,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             ack_i,
  input  logic             clr_i,
  output logic [Width-1:0] q_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             ovr_o
);
  import sipo_rx_pkg::*;

  localparam int CntW = $clog2(Width);

  logic            state, state_n;
  logic [CntW-1:0] cnt, cnt_n;
  logic            sr_en, sr_clr, done;
  logic [Width-1:0] sr_q, word;
  logic            unused_sr_msb;

  sipo_shift_reg #(.Width(Width)) u_sr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (sr_en),
    .clr_i (sr_clr),
    .d_i   (d_i),
    .q_o   (sr_q)
  );

  // The oldest bit falls off on completion; the word is the low bits plus the live bit.
  assign word          = {sr_q[Width-2:0], d_i};
  assign unused_sr_msb = sr_q[Width-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_en   = 1'b0;
    sr_clr  = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_n = ST_SHIFT;
          sr_clr  = 1'b1;
          sr_en   = en_i;
          cnt_n   = en_i ? CntW'(1) : '0;
        end
      end
      default: begin
        // Completion outranks a restart on the same strobe.
        if (en_i && cnt == CntW'(Width-1)) begin
          done    = 1'b1;
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (start_i) begin
          sr_clr = 1'b1;
          sr_en  = en_i;
          cnt_n  = en_i ? CntW'(1) : '0;
        end else if (en_i) begin
          sr_en = 1'b1;
          cnt_n = cnt + CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o     <= '0;
      valid_o <= 1'b0;
      ovr_o   <= 1'b0;
    end else begin
      if (done && (!valid_o || ack_i)) begin
        q_o     <= word;
        valid_o <= 1'b1;
      end else if (ack_i) begin
        valid_o <= 1'b0;
      end
      // Overrun set beats a same-cycle clear.
      if (done && valid_o && !ack_i) ovr_o <= 1'b1;
      else if (clr_i)                ovr_o <= 1'b0;
    end
  end

  assign busy_o = (state == ST_SHIFT);
endmodule
